// File: rtl/biset_target_pkg.sv
// biset_target_pkg
// Shared BiSet link definitions: field widths, the idle control word, helpers
// that pull the write flag and address out of a control word, an address
// window test, and the responder FSM state type.
// Control word layout: {writeEnable, addr[7:0]}; reply layout: {valid, data[31:0]}.
// Optional feature macro used by the responder: BISET_TARGET_TIMEOUT_EN.
package biset_target_pkg;

  localparam int BISET_ADDRLEN  = 8;
  localparam int BISET_DATALEN  = 32;
  localparam int BISET_CTRLLEN  = BISET_ADDRLEN + 1;
  localparam int BISET_REPLYLEN = BISET_DATALEN + 1;

  // An all-zero control word means "no request this cycle".
  localparam logic [BISET_CTRLLEN-1:0] BISET_IDLE = '0;

  typedef enum logic {IDLE, EXT_WAIT} biSetTargetState;

  function automatic logic BiSetCtrlWe(input logic [BISET_CTRLLEN-1:0] ctrl);
    return ctrl[BISET_CTRLLEN-1];
  endfunction

  function automatic logic [BISET_ADDRLEN-1:0] BiSetCtrlAddr(input logic [BISET_CTRLLEN-1:0] ctrl);
    return ctrl[BISET_ADDRLEN-1:0];
  endfunction

  // Window end is formed at 9 bits so a window ending exactly at 256 does
  // not wrap around to zero and reject every address.
  function automatic logic BiSetAddrInRange(input logic [BISET_ADDRLEN-1:0] addr,
                                            input logic [BISET_ADDRLEN-1:0] base,
                                            input logic [BISET_ADDRLEN:0]   size);
    logic [BISET_ADDRLEN:0] addrWide;
    logic [BISET_ADDRLEN:0] baseWide;
    addrWide = {1'b0, addr};
    baseWide = {1'b0, base};
    return (addrWide >= baseWide) && (addrWide < (baseWide + size));
  endfunction

endpackage

// File: rtl/biset_target_ext.sv
// biset_target_ext
// External window handler for the BiSet responder. Latches an accepted
// external request, holds req/we/addr/wdata until ack is seen, then returns a
// single-cycle reply (read data, or zero for writes).
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start_i           accepted external request this cycle (only honoured in IDLE)
//   startWe_i         request is a write
//   startAddr_i       address offset within the external window
//   startWdata_i      write data
//   busy_o            handler is waiting for ack
//   ext_req_o/ext_we_o/ext_addr_o/ext_wdata_o   external handshake outputs
//   ext_ack_i/ext_rdata_i                       external completion and read data
//   replyValid_o/replyData_o                    registered reply
// With BISET_TARGET_TIMEOUT_EN defined an 8-bit wait counter abandons the
// access after TIMEOUT cycles and replies with TIMEOUT_DATA.
module biset_target_ext
  import biset_target_pkg::*;
#(
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic                     startWe_i,
  input  logic [BISET_ADDRLEN-1:0] startAddr_i,
  input  logic [31:0]              startWdata_i,
  output logic                     busy_o,
  output logic                     ext_req_o,
  output logic                     ext_we_o,
  output logic [BISET_ADDRLEN-1:0] ext_addr_o,
  output logic [31:0]              ext_wdata_o,
  input  logic                     ext_ack_i,
  input  logic [31:0]              ext_rdata_i,
  output logic                     replyValid_o,
  output logic [31:0]              replyData_o
);

  biSetTargetState          state_q, state_d;
  logic                     we_q, we_d;
  logic [BISET_ADDRLEN-1:0] addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     replyValid_q, replyValid_d;
  logic [31:0]              replyData_q, replyData_d;

`ifdef BISET_TARGET_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  // Wait counter: counts completed EXT_WAIT cycles since the request was latched.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unusedTimeoutCfg;
  assign unusedTimeoutCfg = ^{TIMEOUT_DATA, 32'(TIMEOUT)};
`endif

  // State and handshake registers; everything the handler drives out is
  // registered so the external port sees clean, glitch-free signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      replyValid_q <= 1'b0;
      replyData_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      replyValid_q <= replyValid_d;
      replyData_q  <= replyData_d;
    end
  end

  // Next-state logic. Ack is checked before the timeout so a completion that
  // lands on the timeout cycle still returns real data. Leaving EXT_WAIT
  // clears the latched request so the port returns to all-zero.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    replyValid_d = 1'b0;
    replyData_d  = '0;
`ifdef BISET_TARGET_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = EXT_WAIT;
          we_d    = startWe_i;
          addr_d  = startAddr_i;
          wdata_d = startWdata_i;
`ifdef BISET_TARGET_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      EXT_WAIT: begin
        if (ext_ack_i) begin
          state_d      = IDLE;
          replyValid_d = 1'b1;
          replyData_d  = we_q ? 32'h0 : ext_rdata_i;
          we_d         = 1'b0;
          addr_d       = '0;
          wdata_d      = '0;
`ifdef BISET_TARGET_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d      = IDLE;
          replyValid_d = 1'b1;
          replyData_d  = TIMEOUT_DATA;
          we_d         = 1'b0;
          addr_d       = '0;
          wdata_d      = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q == EXT_WAIT);
  assign ext_req_o    = (state_q == EXT_WAIT);
  assign ext_we_o     = we_q;
  assign ext_addr_o   = addr_q;
  assign ext_wdata_o  = wdata_q;
  assign replyValid_o = replyValid_q;
  assign replyData_o  = replyData_q;

endmodule

// File: rtl/biset_target.sv
// biset_target
// BiSet responder endpoint. Serves NUM_REGS local 32-bit registers with a
// fixed one-cycle reply and forwards one address window to an external
// req/ack port through biset_target_ext.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   ctrl_in/data_in        request {writeEnable, addr} and write data
//   reply_out              {valid, data}, zero when no reply
//   reg_q/reg_wstb         register contents and per-register bus write strobe
//   hw_we/hw_wdata         hardware-side register load
//   ext_*                  external window handshake
//   overrun                sticky flag: request arrived while external access pending
// Optional feature macro: BISET_TARGET_TIMEOUT_EN (external wait timeout).
module biset_target
  import biset_target_pkg::*;
#(
  parameter logic [7:0]          BASE_ADDR    = 8'h01,
  parameter int                  NUM_REGS     = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK      = '0,
  parameter logic [7:0]          EXT_BASE     = 8'h80,
  parameter logic [7:0]          EXT_SIZE     = 8'h40,
  parameter int                  TIMEOUT      = 255,
  parameter logic [31:0]         TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BISET_CTRLLEN-1:0]  ctrl_in,
  input  logic [BISET_DATALEN-1:0]  data_in,
  output logic [BISET_REPLYLEN-1:0] reply_out,
  output logic [NUM_REGS*32-1:0]    reg_q,
  output logic [NUM_REGS-1:0]       reg_wstb,
  input  logic [NUM_REGS-1:0]       hw_we,
  input  logic [NUM_REGS*32-1:0]    hw_wdata,
  output logic                      ext_req,
  output logic                      ext_we,
  output logic [BISET_ADDRLEN-1:0]  ext_addr,
  output logic [31:0]               ext_wdata,
  input  logic                      ext_ack,
  input  logic [31:0]               ext_rdata,
  output logic                      overrun
);

  logic [NUM_REGS-1:0][31:0] regFile_q, regFile_d;
  logic [NUM_REGS-1:0]       wstb_q, wstb_d;
  logic                      localValid_q, localValid_d;
  logic [31:0]               localData_q, localData_d;
  logic                      overrun_q, overrun_d;

  logic                      reqValid;
  logic                      reqWe;
  logic [BISET_ADDRLEN-1:0]  reqAddr;
  logic                      busy;
  logic                      accept;
  logic                      extHit;
  logic                      extReplyValid;
  logic [31:0]               extReplyData;

  assign reqValid = (ctrl_in != BISET_IDLE);
  assign reqWe    = BiSetCtrlWe(ctrl_in);
  assign reqAddr  = BiSetCtrlAddr(ctrl_in);
  assign accept   = reqValid && !busy;
  assign extHit   = BiSetAddrInRange(reqAddr, EXT_BASE, {1'b0, EXT_SIZE});

  // Local register decode. Hardware loads are applied first so a bus write in
  // the same cycle overrides them. A write to a read-only register replies
  // with whatever the register will hold next cycle, which is its current
  // value unless the hardware side is loading it at the same time.
  always_comb begin
    regFile_d    = regFile_q;
    wstb_d       = '0;
    localValid_d = 1'b0;
    localData_d  = '0;
    overrun_d    = overrun_q | (reqValid && busy);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hw_we[i]) regFile_d[i] = hw_wdata[i*32 +: 32];
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (accept && (reqAddr == 8'(BASE_ADDR + i))) begin
        localValid_d = 1'b1;
        if (!reqWe) begin
          localData_d = regFile_q[i];
        end else if (RO_MASK[i]) begin
          localData_d = regFile_d[i];
        end else begin
          regFile_d[i] = data_in;
          wstb_d[i]    = 1'b1;
          localData_d  = data_in;
        end
      end
    end
  end

  // Local register bank, strobes, local reply and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      regFile_q    <= '0;
      wstb_q       <= '0;
      localValid_q <= 1'b0;
      localData_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      regFile_q    <= regFile_d;
      wstb_q       <= wstb_d;
      localValid_q <= localValid_d;
      localData_q  <= localData_d;
      overrun_q    <= overrun_d;
    end
  end

  biset_target_ext #(
    .TIMEOUT      (TIMEOUT),
    .TIMEOUT_DATA (TIMEOUT_DATA)
  ) u_ext (
    .clk          (clk),
    .reset        (reset),
    .start_i      (accept && extHit),
    .startWe_i    (reqWe),
    .startAddr_i  (8'(reqAddr - EXT_BASE)),
    .startWdata_i (data_in),
    .busy_o       (busy),
    .ext_req_o    (ext_req),
    .ext_we_o     (ext_we),
    .ext_addr_o   (ext_addr),
    .ext_wdata_o  (ext_wdata),
    .ext_ack_i    (ext_ack),
    .ext_rdata_i  (ext_rdata),
    .replyValid_o (extReplyValid),
    .replyData_o  (extReplyData)
  );

  // Local and external replies can never land in the same cycle because
  // local requests are refused while the external access is pending, so the
  // two sources are simply merged.
  assign reply_out = localValid_q  ? {1'b1, localData_q}  :
                     extReplyValid ? {1'b1, extReplyData} : '0;
  assign reg_q     = regFile_q;
  assign reg_wstb  = wstb_q;
  assign overrun   = overrun_q;

endmodule
